// File: rtl/core_mem_stage.sv
// core_mem_stage: memory stage of a simple in-order core.
//   Non-memory instructions pass the ALU result through to a registered
//   writeback bundle with one cycle of latency. Loads and stores issue a
//   single request on the dmem port and stall upstream until it completes.
//   Only one memory transaction is outstanding at a time.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, opcode_i, funct3_i  instruction from EX
//   rd_i, reg_write_i            destination register and write enable
//   alu_result_i, store_data_i   effective address / ALU result, store data
//   dmem_*                       data memory request/response port
//   stall_o                      upstream must hold its inputs
//   wb_*                         registered writeback bundle
//   misaligned_o                 one-cycle pulse for a faulted access
module core_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [6:0]      opcode_i,
    input  logic [2:0]      funct3_i,
    input  logic [4:0]      rd_i,
    input  logic            reg_write_i,
    input  logic [XLEN-1:0] alu_result_i,
    input  logic [XLEN-1:0] store_data_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            stall_o,
    output logic            wb_valid_o,
    output logic            wb_reg_write_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            misaligned_o
);
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_q, state_d;

    // latched request, used while in REQ/RESP
    logic            req_we_q,    req_we_d;
    logic [XLEN-1:0] req_addr_q,  req_addr_d;
    logic [3:0]      req_be_q,    req_be_d;
    logic [XLEN-1:0] req_wdata_q, req_wdata_d;
    logic [1:0]      req_off_q,   req_off_d;
    logic [2:0]      req_f3_q,    req_f3_d;
    logic [4:0]      req_rd_q,    req_rd_d;
    logic            req_rw_q,    req_rw_d;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_rw_q,    wb_rw_d;
    logic [4:0]      wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic            mis_q,      mis_d;

    // decode of the incoming instruction
    logic            is_load, is_store, is_mem, misal;
    logic [3:0]      be_in;
    logic [XLEN-1:0] wdata_in;

    assign is_load  = (opcode_i == OPC_LOAD);
    assign is_store = (opcode_i == OPC_STORE);
    assign is_mem   = is_load | is_store;

    // funct3[1:0] gives the size; encoding 3 is treated as a word access
    always_comb begin
        misal    = 1'b0;
        be_in    = 4'b1111;
        wdata_in = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_in    = 4'b0001 << alu_result_i[1:0];
                wdata_in = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misal    = alu_result_i[0];
                be_in    = 4'b0011 << alu_result_i[1:0];
                wdata_in = {2{store_data_i[15:0]}};
            end
            default: misal = (alu_result_i[1:0] != 2'b00);
        endcase
    end

    // load lane select and extension from the latched offset/size
    logic [XLEN-1:0] sh_b, sh_h, load_val;
    assign sh_b = dmem_rdata_i >> {req_off_q, 3'b000};
    assign sh_h = dmem_rdata_i >> {req_off_q[1], 4'b0000};

    always_comb begin
        case (req_f3_q)
            3'd0:    load_val = {{24{sh_b[7]}}, sh_b[7:0]};
            3'd1:    load_val = {{16{sh_h[15]}}, sh_h[15:0]};
            3'd4:    load_val = {24'd0, sh_b[7:0]};
            3'd5:    load_val = {16'd0, sh_h[15:0]};
            default: load_val = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        req_off_d   = req_off_q;
        req_f3_d    = req_f3_q;
        req_rd_d    = req_rd_q;
        req_rw_d    = req_rw_q;
        wb_valid_d  = 1'b0;
        wb_rw_d     = wb_rw_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mis_d       = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = req_we_q;
        dmem_addr_o  = req_addr_q;
        dmem_be_o    = req_be_q;
        dmem_wdata_o = req_wdata_q;
        stall_o      = 1'b0;

        case (state_q)
            IDLE: if (valid_i) begin
                if (!is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = reg_write_i;
                    wb_rd_d    = rd_i;
                    wb_data_d  = alu_result_i;
                end else if (misal) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = 1'b0;
                    wb_rd_d    = rd_i;
                    mis_d      = 1'b1;
                end else begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = is_store;
                    dmem_addr_o  = {alu_result_i[XLEN-1:2], 2'b00};
                    dmem_be_o    = be_in;
                    dmem_wdata_o = wdata_in;
                    req_we_d     = is_store;
                    req_addr_d   = {alu_result_i[XLEN-1:2], 2'b00};
                    req_be_d     = be_in;
                    req_wdata_d  = wdata_in;
                    req_off_d    = alu_result_i[1:0];
                    req_f3_d     = funct3_i;
                    req_rd_d     = rd_i;
                    req_rw_d     = reg_write_i;
                    if (dmem_gnt_i && is_store) begin
                        // store done on grant, stage free next cycle
                        wb_valid_d = 1'b1;
                        wb_rw_d    = 1'b0;
                        wb_rd_d    = rd_i;
                    end else begin
                        stall_o = 1'b1;
                        state_d = dmem_gnt_i ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                dmem_req_o = 1'b1;
                stall_o    = 1'b1;
                if (dmem_gnt_i) begin
                    if (req_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_rw_d    = 1'b0;
                        wb_rd_d    = req_rd_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                stall_o = 1'b1;
                if (dmem_rvalid_i) begin
                    wb_valid_d = 1'b1;
                    wb_rw_d    = req_rw_q;
                    wb_rd_d    = req_rd_q;
                    wb_data_d  = load_val;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // nothing leaves the stage while reset is held
        if (rst_i) begin
            dmem_req_o = 1'b0;
            stall_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
            req_off_q   <= '0;
            req_f3_q    <= '0;
            req_rd_q    <= '0;
            req_rw_q    <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rw_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
            req_off_q   <= req_off_d;
            req_f3_q    <= req_f3_d;
            req_rd_q    <= req_rd_d;
            req_rw_q    <= req_rw_d;
            wb_valid_q  <= wb_valid_d;
            wb_rw_q     <= wb_rw_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mis_q       <= mis_d;
        end
    end

    assign wb_valid_o     = wb_valid_q;
    assign wb_reg_write_o = wb_rw_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign misaligned_o   = mis_q;
endmodule

// File: tb/tb_core_mem_stage.sv
// Bench for core_mem_stage: table of single-instruction vectors plus
// hand-written sequences for reset-in-flight and back-to-back issue.
// Writeback expectations go into a queue when an instruction is driven and
// are checked in order by a monitor whenever wb_valid_o is seen.
module tb_core_mem_stage;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_ST  = 7'h23;
    localparam logic [6:0] OP_ALU = 7'h33;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        reg_write_i;
    logic [31:0] alu_result_i, store_data_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o, wb_valid_o, wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misaligned_o;

    core_mem_stage #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .rd_i(rd_i), .reg_write_i(reg_write_i),
        .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .misaligned_o(misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] data;
        bit          chk_data;
        logic        mis;
    } exp_t;
    exp_t exp_q[$];

    // in-order writeback scoreboard
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (wb_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {31'd0, wb_valid_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
                    chk("wb_rw", {31'd0, wb_reg_write_o}, {31'd0, e.rw});
                    chk("wb_mis", {31'd0, misaligned_o}, {31'd0, e.mis});
                    if (e.chk_data) chk("wb_data", wb_data_o, e.data);
                end
            end else begin
                chk("mis_quiet", {31'd0, misaligned_o}, 32'd0);
            end
        end
    end

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu, sdata, rdata;
        int          dly;
        logic        ereq;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewdata, ewb;
        logic        emis;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic rw, input logic [31:0] alu, input logic [31:0] sdata,
                       input logic [31:0] rdata, input int dly, input logic ereq,
                       input logic [31:0] eaddr, input logic [3:0] ebe,
                       input logic [31:0] ewdata, input logic [31:0] ewb, input logic emis);
        vec_t v;
        v.op = op; v.f3 = f3; v.rd = rd; v.rw = rw; v.alu = alu; v.sdata = sdata;
        v.rdata = rdata; v.dly = dly; v.ereq = ereq; v.eaddr = eaddr; v.ebe = ebe;
        v.ewdata = ewdata; v.ewb = ewb; v.emis = emis;
        tbl.push_back(v);
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; opcode_i = OP_ALU; funct3_i = 3'd0; rd_i = 5'd0;
        reg_write_i = 1'b0; alu_result_i = 32'd0; store_data_i = 32'd0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'd0;
    endtask

    task automatic chk_req(input string tag, input vec_t v);
        chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd1);
        chk({tag, "_we"}, {31'd0, dmem_we_o}, {31'd0, v.op == OP_ST});
        chk({tag, "_addr"}, dmem_addr_o, v.eaddr);
        chk({tag, "_be"}, {28'd0, dmem_be_o}, {28'd0, v.ebe});
        if (v.op == OP_ST) chk({tag, "_wdata"}, dmem_wdata_o, v.ewdata);
    endtask

    // One instruction: issue, hold through grant delay, return data one
    // cycle after grant for loads, then expect the writeback pulse.
    task automatic run(input vec_t v);
        exp_t e;
        logic is_ld;
        is_ld = (v.op == OP_LD);
        @(posedge clk_i); #1;
        valid_i = 1'b1; opcode_i = v.op; funct3_i = v.f3; rd_i = v.rd;
        reg_write_i = v.rw; alu_result_i = v.alu; store_data_i = v.sdata;
        dmem_gnt_i = v.ereq && (v.dly == 0);
        e.rd = v.rd; e.rw = v.ereq ? (is_ld && v.rw) : (v.emis ? 1'b0 : v.rw);
        e.data = v.ewb; e.chk_data = v.ereq ? is_ld : !v.emis; e.mis = v.emis;
        exp_q.push_back(e);
        @(negedge clk_i);
        chk("issue_req", {31'd0, dmem_req_o}, {31'd0, v.ereq});
        if (v.ereq) chk_req("issue", v);
        chk("issue_stall", {31'd0, stall_o}, {31'd0, v.ereq && (is_ld || v.dly != 0)});
        for (int k = 1; k <= v.dly; k++) begin
            @(posedge clk_i); #1;
            // scramble the inputs: the latched request must be used
            valid_i = 1'b0; alu_result_i = 32'hDEAD_BEEF; store_data_i = 32'h5555_AAAA;
            funct3_i = 3'd2; opcode_i = OP_ALU;
            dmem_gnt_i = (k == v.dly);
            @(negedge clk_i);
            chk_req("hold", v);
            chk("hold_stall", {31'd0, stall_o}, 32'd1);
        end
        @(posedge clk_i); #1;
        idle_inputs();
        if (is_ld && v.ereq) begin
            dmem_rvalid_i = 1'b1; dmem_rdata_i = v.rdata;
            @(negedge clk_i);
            chk("resp_req", {31'd0, dmem_req_o}, 32'd0);
            chk("resp_stall", {31'd0, stall_o}, 32'd1);
            @(posedge clk_i); #1;
            dmem_rvalid_i = 1'b0;
        end
        @(negedge clk_i);
        chk("wb_pulse", {31'd0, wb_valid_o}, 32'd1);
        chk("free_stall", {31'd0, stall_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_i = 1'b1;
        //    op      f3    rd  rw alu           sdata         rdata         dly req eaddr        be       ewdata        ewb           mis
        add(OP_ALU, 3'd0, 5'd5, 1, 32'h0000_1234, 32'd0,        32'd0,        0, 0, 32'd0,       4'b0000, 32'd0,        32'h0000_1234, 0);
        add(OP_LD,  3'd0, 5'd7, 1, 32'h0000_0103, 32'd0,        32'h80FF_FF7F, 0, 1, 32'h100,    4'b1000, 32'd0,        32'hFFFF_FF80, 0);
        add(OP_LD,  3'd4, 5'd8, 1, 32'h0000_0103, 32'd0,        32'h80FF_FF7F, 0, 1, 32'h100,    4'b1000, 32'd0,        32'h0000_0080, 0);
        add(OP_ST,  3'd1, 5'd0, 0, 32'h0000_0202, 32'h0000_ABCD, 32'd0,       3, 1, 32'h200,     4'b1100, 32'hABCD_ABCD, 32'd0,        0);
        add(OP_LD,  3'd2, 5'd9, 1, 32'h0000_0101, 32'd0,        32'd0,        0, 0, 32'd0,       4'b0000, 32'd0,        32'd0,        1);
        add(OP_ST,  3'd0, 5'd0, 0, 32'h0000_0001, 32'h1234_5678, 32'd0,       0, 1, 32'h0,       4'b0010, 32'h7878_7878, 32'd0,        0);
        add(OP_ST,  3'd2, 5'd0, 0, 32'h0000_0010, 32'hCAFE_BABE, 32'd0,       1, 1, 32'h10,      4'b1111, 32'hCAFE_BABE, 32'd0,        0);
        add(OP_LD,  3'd1, 5'd3, 1, 32'h0000_0002, 32'd0,        32'h8001_0000, 0, 1, 32'h0,      4'b1100, 32'd0,        32'hFFFF_8001, 0);
        add(OP_LD,  3'd5, 5'd4, 1, 32'h0000_0002, 32'd0,        32'h8001_0000, 0, 1, 32'h0,      4'b1100, 32'd0,        32'h0000_8001, 0);
        add(OP_LD,  3'd2, 5'd6, 1, 32'h0000_0008, 32'd0,        32'h1234_5678, 2, 1, 32'h8,      4'b1111, 32'd0,        32'h1234_5678, 0);
        add(OP_ST,  3'd1, 5'd0, 0, 32'h0000_0003, 32'h0000_1111, 32'd0,       0, 0, 32'd0,       4'b0000, 32'd0,        32'd0,        1);
        add(OP_LD,  3'd5, 5'd2, 1, 32'h0000_0001, 32'd0,        32'd0,        0, 0, 32'd0,       4'b0000, 32'd0,        32'd0,        1);
        add(OP_LD,  3'd0, 5'd1, 1, 32'h0000_0000, 32'd0,        32'h0000_007F, 0, 1, 32'h0,      4'b0001, 32'd0,        32'h0000_007F, 0);
        add(OP_ALU, 3'd0, 5'd0, 0, 32'hFFFF_FFFF, 32'd0,        32'd0,        0, 0, 32'd0,       4'b0000, 32'd0,        32'hFFFF_FFFF, 0);
        add(OP_LD,  3'd1, 5'd10, 1, 32'h0000_0000, 32'd0,       32'hFFFF_7FFF, 0, 1, 32'h0,      4'b0011, 32'd0,        32'h0000_7FFF, 0);

        // reset state, with an aligned load presented during reset
        @(posedge clk_i); #1;
        valid_i = 1'b1; opcode_i = OP_LD; funct3_i = 3'd2; alu_result_i = 32'h40;
        @(negedge clk_i);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_reg_write_o}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_mis", {31'd0, misaligned_o}, 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        rst_i = 1'b0;
        // valid_i=0 with a load opcode: no request, no writeback
        opcode_i = OP_LD; alu_result_i = 32'h44;
        @(negedge clk_i);
        chk("novalid_req", {31'd0, dmem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("novalid_wb", {31'd0, wb_valid_o}, 32'd0);

        foreach (tbl[i]) run(tbl[i]);

        // reset while waiting for load data; late rvalid is dropped
        @(posedge clk_i); #1;
        valid_i = 1'b1; opcode_i = OP_LD; funct3_i = 3'd2; rd_i = 5'd11;
        reg_write_i = 1'b1; alu_result_i = 32'h100; dmem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstmid_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rstmid_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        @(negedge clk_i);
        chk("rstmid_idle_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid_no_wb", {31'd0, wb_valid_o}, 32'd0);

        // LH then ADD, upstream holding the LH while stalled
        @(posedge clk_i); #1;
        valid_i = 1'b1; opcode_i = OP_LD; funct3_i = 3'd1; rd_i = 5'd12;
        reg_write_i = 1'b1; alu_result_i = 32'h2; dmem_gnt_i = 1'b1;
        exp_q.push_back('{rd: 5'd12, rw: 1'b1, data: 32'hFFFF_8001, chk_data: 1'b1, mis: 1'b0});
        @(negedge clk_i);
        chk("b2b_stall0", {31'd0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h8001_0000;
        @(negedge clk_i);
        chk("b2b_stall1", {31'd0, stall_o}, 32'd1);
        chk("b2b_noreissue", {31'd0, dmem_req_o}, 32'd0);
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        opcode_i = OP_ALU; funct3_i = 3'd0; rd_i = 5'd13; alu_result_i = 32'h0000_0042;
        exp_q.push_back('{rd: 5'd13, rw: 1'b1, data: 32'h0000_0042, chk_data: 1'b1, mis: 1'b0});
        @(negedge clk_i);
        chk("b2b_accept", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("b2b_add_wb", {31'd0, wb_valid_o}, 32'd1);
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("b2b_pulse_end", {31'd0, wb_valid_o}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
